// File: rtl/bsr_pkg.sv
// Shared types and defaults for the bidirectional shift register.
package bsr_pkg;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } bsr_dir_e;

  localparam int BSR_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/bidirectional_shift_register_if.sv
// Control and data bundle for the bidirectional shift register.
// Optional feature macro: BSR_PARALLEL_LOAD_EN adds load/load_data.
interface bidirectional_shift_register_if #(
  parameter int WIDTH = bsr_pkg::BSR_DEFAULT_WIDTH
);

  logic             shift;
  logic             direction;
  logic             data_in;
  logic [WIDTH-1:0] data_out;

`ifdef BSR_PARALLEL_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] load_data;

  modport master (
    output shift, direction, data_in, load, load_data,
    input  data_out
  );

  modport slave (
    input  shift, direction, data_in, load, load_data,
    output data_out
  );
`else
  modport master (
    output shift, direction, data_in,
    input  data_out
  );

  modport slave (
    input  shift, direction, data_in,
    output data_out
  );
`endif

endinterface

// File: rtl/bsr_next_state.sv
// Combinational next-value logic: load (optional) > shift > hold.
// Optional feature macro: BSR_PARALLEL_LOAD_EN.
module bsr_next_state
  import bsr_pkg::*;
#(
  parameter int WIDTH = BSR_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] current,
  input  logic             shift,
  input  bsr_dir_e         direction,
  input  logic             data_in,
`ifdef BSR_PARALLEL_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`endif
  output logic [WIDTH-1:0] next_value
);

  always_comb begin
    // NOTE: default assignment first so every path drives next_value; no latch.
    next_value = current;
    if (shift) begin
      if (direction == DIR_LEFT) next_value = {current[WIDTH-2:0], data_in};
      else                       next_value = {data_in, current[WIDTH-1:1]};
    end
`ifdef BSR_PARALLEL_LOAD_EN
    // Later assignment wins, so load overrides any shift.
    if (load) next_value = load_data;
`endif
  end

endmodule

// File: rtl/bidirectional_shift_register.sv
// Serial-in, parallel-out shift register: state register plus synchronous reset mux.
// Optional feature macro: BSR_PARALLEL_LOAD_EN (parallel load port).
module bidirectional_shift_register
  import bsr_pkg::*;
#(
  parameter int               WIDTH       = BSR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                          clk,
  input logic                          reset,
  bidirectional_shift_register_if.slave bus
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  bsr_next_state #(
    .WIDTH (WIDTH)
  ) u_next_state (
    .current    (state_q),
    .shift      (bus.shift),
    .direction  (bsr_dir_e'(bus.direction)),
    .data_in    (bus.data_in),
`ifdef BSR_PARALLEL_LOAD_EN
    .load       (bus.load),
    .load_data  (bus.load_data),
`endif
    .next_value (state_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so all flops update together.
    if (reset) state_q <= RESET_VALUE;
    else       state_q <= state_d;
  end

  assign bus.data_out = state_q;

endmodule

// File: tb/tb_bidirectional_shift_register.sv
// Self-checking bench: directed scenarios plus random stimulus against an arithmetic model.
// Honours BSR_PARALLEL_LOAD_EN when defined.
module tb_bidirectional_shift_register;

  localparam int           W    = 4;
  localparam logic [W-1:0] RSTV = '0;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bidirectional_shift_register_if #(.WIDTH(W)) bus ();

  bidirectional_shift_register #(
    .WIDTH       (W),
    .RESET_VALUE (RSTV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int model;  // reference contents held as an unsigned integer

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Apply inputs, advance one edge, update the model, sample on the falling edge.
  task automatic step(input string tag, input logic rst, input logic sh, input logic dir,
                      input logic din, input logic ld, input logic [W-1:0] ldd);
    reset         = rst;
    bus.shift     = sh;
    bus.direction = dir;
    bus.data_in   = din;
`ifdef BSR_PARALLEL_LOAD_EN
    bus.load      = ld;
    bus.load_data = ldd;
`endif
    @(posedge clk);
    if (rst)                          model = int'(RSTV);
`ifdef BSR_PARALLEL_LOAD_EN
    else if (ld)                      model = int'(ldd);
`endif
    else if (sh && dir)               model = (model * 2 + int'(din)) % (2 ** W);
    else if (sh)                      model = model / 2 + int'(din) * (2 ** (W - 1));
    @(negedge clk);
    check(tag, bus.data_out, W'(model));
  endtask

  logic [3:0] left_din  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] left_exp  [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
  logic [3:0] left2_din [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] left2_exp [3] = '{4'b0110, 4'b1101, 4'b1010};
  logic [3:0] right_din [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] right_exp [3] = '{4'b0101, 4'b1010, 4'b0101};

  initial begin
    reset         = 1'b0;
    bus.shift     = 1'b0;
    bus.direction = 1'b0;
    bus.data_in   = 1'b0;
`ifdef BSR_PARALLEL_LOAD_EN
    bus.load      = 1'b0;
    bus.load_data = '0;
`endif
    model = 0;
    @(negedge clk);

    // 1: reset with arbitrary inputs, then held with shift active
    step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("reset_const", bus.data_out, 4'b0000);
    step("reset_hold0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step("reset_hold1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);

    // 2: left fill
    for (int i = 0; i < 4; i++) begin
      step("left_fill", 1'b0, 1'b1, 1'b1, left_din[i][0], 1'b0, '0);
      check("left_fill_const", bus.data_out, left_exp[i]);
    end

    // 3: continue left, bits falling off the MSB
    for (int i = 0; i < 3; i++) begin
      step("left_over", 1'b0, 1'b1, 1'b1, left2_din[i][0], 1'b0, '0);
      check("left_over_const", bus.data_out, left2_exp[i]);
    end

    // 4: right shifts
    for (int i = 0; i < 3; i++) begin
      step("right", 1'b0, 1'b1, 1'b0, right_din[i][0], 1'b0, '0);
      check("right_const", bus.data_out, right_exp[i]);
    end

    // 5: hold while direction/data_in toggle, then reset mid-shift
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 1'b0, i[0], ~i[0], 1'b0, '0);
      check("hold_const", bus.data_out, 4'b0101);
    end
    step("mid_shift", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step("mid_reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("mid_reset_const", bus.data_out, 4'b0000);

`ifdef BSR_PARALLEL_LOAD_EN
    // 6: parallel load overrides shift; reset overrides load
    step("load", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
    check("load_const", bus.data_out, 4'b1011);
    step("load_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1111);
    check("load_reset_const", bus.data_out, 4'b0000);
`endif

    // Random stimulus against the model, including occasional resets
    for (int i = 0; i < 400; i++) begin
      logic r_rst, r_sh, r_dir, r_din, r_ld;
      logic [W-1:0] r_ldd;
      r_rst = ($urandom_range(0, 19) == 0);
      r_sh  = ($urandom_range(0, 3) != 0);
      r_dir = 1'($urandom);
      r_din = 1'($urandom);
`ifdef BSR_PARALLEL_LOAD_EN
      r_ld  = ($urandom_range(0, 9) == 0);
`else
      r_ld  = 1'b0;
`endif
      r_ldd = W'($urandom);
      step("random", r_rst, r_sh, r_dir, r_din, r_ld, r_ldd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
